// File: rtl/rv_csr_cnt_ctrl_if.sv
// rtl/rv_csr_cnt_ctrl_if.sv - two-port CSR request/response bundle for the counter controller
interface rv_csr_cnt_ctrl_if;
   logic [1:0]  i_req_valid;
   logic [1:0]  i_req_write;
   logic [7:0]  i_req_idx0;
   logic [7:0]  i_req_idx1;
   logic [31:0] i_req_wdata0;
   logic [31:0] i_req_wdata1;
   logic [1:0]  o_req_ready;
   logic        o_rsp_valid;
   logic        o_rsp_port;
   logic [31:0] o_rsp_data;
   logic        o_rsp_err;

   modport master (
      output i_req_valid, i_req_write, i_req_idx0, i_req_idx1, i_req_wdata0, i_req_wdata1,
      input  o_req_ready, o_rsp_valid, o_rsp_port, o_rsp_data, o_rsp_err
   );

   modport slave (
      input  i_req_valid, i_req_write, i_req_idx0, i_req_idx1, i_req_wdata0, i_req_wdata1,
      output o_req_ready, o_rsp_valid, o_rsp_port, o_rsp_data, o_rsp_err
   );
endinterface

// File: rtl/rv_csr_cnt_ctrl.sv
// rtl/rv_csr_cnt_ctrl.sv - Zicntr cycle/instret counters and mcountinhibit with two-port arbitration
module rv_csr_cnt_ctrl #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_instruction_executed,
   rv_csr_cnt_ctrl_if.slave     bus,
   output logic [2:0]           o_inhibit
);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic [63:0] cycle_q;
   logic [63:0] instret_q;
   logic [1:0]  inh_q;
   logic [3:0]  starve_q;

   logic        grant0;
   logic        grant1;
   logic        accept;
   logic        sel_write;
   logic [7:0]  sel_idx;
   logic [31:0] sel_wdata;
   logic [31:0] rd_data;
   logic        err;
   logic        wr_cyc_lo;
   logic        wr_cyc_hi;
   logic        wr_ir_lo;
   logic        wr_ir_hi;
   logic        wr_inh;

   always_comb begin
      grant1    = bus.i_req_valid[1] & (~bus.i_req_valid[0] | (starve_q == STARVE_MAX));
      grant0    = bus.i_req_valid[0] & ~grant1;
      accept    = grant0 | grant1;
      sel_write = grant1 ? bus.i_req_write[1] : bus.i_req_write[0];
      sel_idx   = grant1 ? bus.i_req_idx1 : bus.i_req_idx0;
      sel_wdata = grant1 ? bus.i_req_wdata1 : bus.i_req_wdata0;
   end

   assign bus.o_req_ready = {grant1, grant0};
   assign o_inhibit       = {inh_q[1], 1'b0, inh_q[0]};

   // Write strobes are raw decode; they only take effect when qualified by accept.
   always_comb begin
      rd_data   = '0;
      err       = 1'b0;
      wr_cyc_lo = 1'b0;
      wr_cyc_hi = 1'b0;
      wr_ir_lo  = 1'b0;
      wr_ir_hi  = 1'b0;
      wr_inh    = 1'b0;
      case (sel_idx)
         8'h00: begin rd_data = cycle_q[31:0];    wr_cyc_lo = sel_write; end
         8'h80: begin rd_data = cycle_q[63:32];   wr_cyc_hi = sel_write; end
         8'h01: begin rd_data = cycle_q[31:0];    err = sel_write;       end
         8'h81: begin rd_data = cycle_q[63:32];   err = sel_write;       end
         8'h02: begin rd_data = instret_q[31:0];  wr_ir_lo = sel_write;  end
         8'h82: begin rd_data = instret_q[63:32]; wr_ir_hi = sel_write;  end
         8'h20: begin rd_data = {29'd0, inh_q[1], 1'b0, inh_q[0]}; wr_inh = sel_write; end
         default: err = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         starve_q <= '0;
      end else if (grant1 | ~bus.i_req_valid[1]) begin
         starve_q <= '0;
      end else if (grant0) begin
         starve_q <= starve_q + 4'd1;
      end
   end

   // A software write to a half replaces only that half and drops the same-cycle increment.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cycle_q   <= '0;
         instret_q <= '0;
         inh_q     <= '0;
      end else begin
         if (accept & wr_cyc_lo)
            cycle_q <= {cycle_q[63:32], sel_wdata};
         else if (accept & wr_cyc_hi)
            cycle_q <= {sel_wdata, cycle_q[31:0]};
         else if (!inh_q[0])
            cycle_q <= cycle_q + 64'd1;

         if (accept & wr_ir_lo)
            instret_q <= {instret_q[63:32], sel_wdata};
         else if (accept & wr_ir_hi)
            instret_q <= {sel_wdata, instret_q[31:0]};
         else if (i_instruction_executed & ~inh_q[1])
            instret_q <= instret_q + 64'd1;

         if (accept & wr_inh)
            inh_q <= {sel_wdata[2], sel_wdata[0]};
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         bus.o_rsp_valid <= 1'b0;
         bus.o_rsp_port  <= 1'b0;
         bus.o_rsp_data  <= '0;
         bus.o_rsp_err   <= 1'b0;
      end else begin
         bus.o_rsp_valid <= accept;
         bus.o_rsp_port  <= grant1;
         bus.o_rsp_data  <= (accept & ~sel_write & ~err) ? rd_data : 32'd0;
         bus.o_rsp_err   <= accept & err;
      end
   end
endmodule
